harmonic_synth_engine: RTL
==========================

// Module: harmonic_synth_engine
// PURPOSE
//  Parametrised additive synthesiser: one phase accumulator, NUM_HARM harmonics, sin and cos amplitude per harmonic.
//  One shared sine LUT and MAC are time-multiplexed over the harmonics at each sample tick.
//  Output is a saturated signed sample plus a valid strobe, feeding the PWM generator.
//  Successor to the 8-instance fixed LUT/scaler array: harmonic count, widths and rate are parameters.
//  Adds a phase accumulator, staged config, saturation and overrun detection.
// PARAMETERS
//  NUM_HARM  8      number of harmonics k=1..NUM_HARM (1..16)
//  AMP_W     8      unsigned amplitude width
//  PHASE_W   16     phase accumulator width (>=8)
//  OUT_W     16     signed output sample width
//  TICK_DIV  10000  clk cycles per sample tick (>= NUM_HARM+3 for no overrun)
// PORTS
//  clk         in   1                  system clock, 100 MHz
//  reset_n     in   1                  synchronous reset, active low
//  enable      in   1                  1 = tick divider runs; 0 = divider and phase frozen
//  phase_inc   in   PHASE_W            fundamental phase step per tick
//  cfg_we      in   1                  amplitude write strobe
//  cfg_addr    in   $clog2(NUM_HARM)+1 {harmonic index (0 = k1), sel}; sel 0 = cos, 1 = sin
//  cfg_data    in   AMP_W              amplitude value
//  clr_overrun in   1                  clears the overrun flag
//  sample_out  out  OUT_W              signed sample, held between updates
//  sample_vld  out  1                  1-cycle pulse when sample_out updates
//  busy        out  1                  1 while in LOAD/ACCUM/SAT
//  overrun     out  1                  sticky: a tick arrived while busy
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): phase, divider, all amplitudes, accumulator, sample_out = 0; sample_vld, busy, overrun = 0; FSM = IDLE.
//  Reset has priority over every other input, including mid-ACCUM.
//  Tick: divider counts 0..TICK_DIV-1 while enable=1; tick is a 1-cycle pulse at count TICK_DIV-1, then wrap to 0.
//  Phase update on tick: phase <= phase + phase_inc, modulo 2^PHASE_W. Phase only changes on ticks.
//  LUT: 256 entries, lut[i] = round(127*sin(2*pi*i/256)), signed 8 bit. Reads are registered (1-cycle latency).
//  Harmonic k index: p = phase[PHASE_W-1 -: 8]; sin addr = (k*p) mod 256; cos addr = (k*p + 64) mod 256.
//  Config: cfg_we writes the staging register file any cycle. The active set is copied from staging in LOAD.
//    A write during ACCUM therefore takes effect at the next sample. Same-cycle write and LOAD: the new value is used.
//  MAC: per harmonic, acc += a_cos[k]*cos_k + a_sin[k]*sin_k.
//    Each product is signed AMP_W+9 bit. acc is AMP_W+9+$clog2(2*NUM_HARM) bits, so it cannot overflow.
//  FSM
//    IDLE  -> LOAD on tick: latch phase, copy staging set to active set, clear acc, busy=1.
//    LOAD  -> ACCUM after 1 cycle, with the LUT read for k=1 issued.
//    ACCUM: one harmonic per cycle, NUM_HARM cycles; -> SAT after the last harmonic.
//    SAT   -> IDLE: sample_out <= clamp(acc, -2^(OUT_W-1), 2^(OUT_W-1)-1); sample_vld=1 this cycle; busy=0.
//  Latency: sample_vld asserts NUM_HARM+2 cycles after the tick cycle.
//  Overrun: a tick with busy=1 is dropped; phase is not advanced; overrun <= 1.
//    clr_overrun clears it; a simultaneous tick-while-busy wins (stays 1).
//  enable=0 mid-sample: the current sample completes; the divider holds its count.
//  Zero amplitudes give sample_out = 0 with a normal sample_vld pulse.
// TESTING
//  1 Reset: hold reset_n=0 across a tick and mid-ACCUM -> all outputs 0, FSM IDLE, next valid needs a full TICK_DIV.
//  2 Cos k1=255, rest 0, phase_inc=0 -> sample_out=32385 (255*127), vld exactly 10 cycles after tick (N=8).
//  3 Sin k1=255, phase_inc=16'h4000 -> successive samples 32385, 0, -32385, 0, 32385 (phase wraps).
//  4 All 16 amplitudes=255, phase_inc=0 -> raw 259080 clamps to 32767; then cos k1=255 only with
//    phase_inc=16'h8000 -> sample 2 = -32385, no clamp.
//  5 TICK_DIV=6, N=8 -> overrun=1, phase advances once per accepted sample; clr_overrun -> 0.
//  6 cfg_we cos k1 0->100 mid-ACCUM -> current sample uses 0, next sample = 12700.

Source files
------------

// File: rtl/harmonic_synth_engine.sv
// Additive synthesiser: one phase accumulator, NUM_HARM harmonics with cos/sin amplitudes,
// a shared quarter-wave sine LUT and a single MAC time-multiplexed over harmonics per sample tick.
module harmonic_synth_engine #(
    parameter int unsigned NUM_HARM = 8,
    parameter int unsigned AMP_W    = 8,
    parameter int unsigned PHASE_W  = 16,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned TICK_DIV = 10000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [PHASE_W-1:0]            phase_inc,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_HARM):0]     cfg_addr,
    input  logic [AMP_W-1:0]              cfg_data,
    input  logic                          clr_overrun,
    output logic signed [OUT_W-1:0]       sample_out,
    output logic                          sample_vld,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned ADDR_W = $clog2(NUM_HARM) + 1;
    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
    localparam int unsigned PROD_W = AMP_W + 9;
    localparam int unsigned ACC_W  = AMP_W + 9 + $clog2(2 * NUM_HARM);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    // First quadrant of round(127*sin(2*pi*i/256)), i = 0..64; the rest follows by symmetry.
    localparam logic [6:0] QTAB [65] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
        7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
        7'd60,  7'd63,  7'd65,  7'd68,  7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
        7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
        7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
        7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    function automatic logic signed [7:0] lut_val(input logic [7:0] a);
        logic [6:0] mag;
        mag = a[6] ? QTAB[7'd64 - {1'b0, a[5:0]}] : QTAB[{1'b0, a[5:0]}];
        return a[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACCUM, S_SAT} state_t;
    state_t r_state, w_next;

    logic [DIV_W-1:0]         r_div;
    logic [PHASE_W-1:0]       r_phase;
    logic [7:0]               r_lp;
    logic [IDX_W-1:0]         r_k;
    logic signed [ACC_W-1:0]  r_acc, w_acc_next;
    logic signed [7:0]        r_sin, r_cos;
    logic signed [OUT_W-1:0]  r_sample, w_clamp;
    logic                     r_ovr;
    logic [AMP_W-1:0]         r_stg_cos [NUM_HARM];
    logic [AMP_W-1:0]         r_stg_sin [NUM_HARM];
    logic [AMP_W-1:0]         r_act_cos [NUM_HARM];
    logic [AMP_W-1:0]         r_act_sin [NUM_HARM];
    logic [NUM_HARM-1:0]      w_hit_cos, w_hit_sin;
    logic                     w_tick, w_accept, w_last;
    logic [7:0]               w_mult, w_sin_addr, w_cos_addr;
    logic signed [PROD_W-1:0] w_pc, w_ps;

    assign w_tick   = enable && (r_div == DIV_W'(TICK_DIV - 1));
    assign w_accept = w_tick && (r_state == S_IDLE);
    assign w_last   = (r_k == IDX_W'(NUM_HARM - 1));

    always_ff @(posedge clk) begin : p_state
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin : p_next
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LOAD;
            S_LOAD:  w_next = S_ACCUM;
            S_ACCUM: if (w_last) w_next = S_SAT;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin : p_out
        busy       = (r_state != S_IDLE);
        sample_vld = (r_state == S_SAT);
    end

    // LOAD issues the read for k=1; each ACCUM cycle consumes harmonic r_k+1 and issues r_k+2.
    assign w_mult     = (r_state == S_LOAD) ? 8'd1 : 8'(r_k) + 8'd2;
    assign w_sin_addr = w_mult * r_lp;
    assign w_cos_addr = w_sin_addr + 8'd64;

    assign w_pc       = PROD_W'($signed({1'b0, r_act_cos[r_k]})) * PROD_W'(r_cos);
    assign w_ps       = PROD_W'($signed({1'b0, r_act_sin[r_k]})) * PROD_W'(r_sin);
    assign w_acc_next = r_acc + ACC_W'(w_pc) + ACC_W'(w_ps);

    always_comb begin : p_clamp
        if (w_acc_next > SAT_HI)      w_clamp = OUT_W'(SAT_HI);
        else if (w_acc_next < SAT_LO) w_clamp = OUT_W'(SAT_LO);
        else                          w_clamp = OUT_W'(w_acc_next);
    end

    always_comb begin : p_cfg_decode
        w_hit_cos = '0;
        w_hit_sin = '0;
        for (int unsigned k = 0; k < NUM_HARM; k++) begin
            if (cfg_we && ((cfg_addr >> 1) == ADDR_W'(k))) begin
                if (cfg_addr[0]) w_hit_sin[k] = 1'b1;
                else             w_hit_cos[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin : p_data
        if (!reset_n) begin
            r_div    <= '0;
            r_phase  <= '0;
            r_lp     <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_sin    <= '0;
            r_cos    <= '0;
            r_sample <= '0;
            r_ovr    <= 1'b0;
            for (int unsigned k = 0; k < NUM_HARM; k++) begin
                r_stg_cos[k] <= '0;
                r_stg_sin[k] <= '0;
                r_act_cos[k] <= '0;
                r_act_sin[k] <= '0;
            end
        end else begin
            if (enable) r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_accept) begin
                r_lp    <= r_phase[PHASE_W-1 -: 8];
                r_phase <= r_phase + phase_inc;
                r_acc   <= '0;
            end
            if (w_tick && busy)   r_ovr <= 1'b1;
            else if (clr_overrun) r_ovr <= 1'b0;
            r_sin <= lut_val(w_sin_addr);
            r_cos <= lut_val(w_cos_addr);
            // A write landing in the LOAD cycle bypasses staging so the new value is used.
            for (int unsigned k = 0; k < NUM_HARM; k++) begin
                if (w_hit_cos[k]) r_stg_cos[k] <= cfg_data;
                if (w_hit_sin[k]) r_stg_sin[k] <= cfg_data;
                if (r_state == S_LOAD) begin
                    r_act_cos[k] <= w_hit_cos[k] ? cfg_data : r_stg_cos[k];
                    r_act_sin[k] <= w_hit_sin[k] ? cfg_data : r_stg_sin[k];
                end
            end
            if (r_state == S_LOAD) r_k <= '0;
            if (r_state == S_ACCUM) begin
                r_acc <= w_acc_next;
                r_k   <= r_k + IDX_W'(1);
                if (w_last) r_sample <= w_clamp;
            end
        end
    end

    assign sample_out = r_sample;
    assign overrun    = r_ovr;

endmodule
